t07_mem_arbiter: RTL

T07_MEM_ARBITER -- requirements
Module: t07_mem_arbiter

---
 rtl/t07_mem_pkg.sv | 9 +
 rtl/t07_bus_timer.sv | 19 +
 rtl/t07_mem_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/t07_mem_pkg.sv
// t07_mem_pkg: shared arbiter state encoding, CPU request codes and the timeout fill word.
package t07_mem_pkg;
  typedef enum logic [1:0] {IDLE, CPU_ACC, PER_ACC, CPU_DONE} arb_state_t;
  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_WRITE = 2'b01;
  localparam logic [1:0] RWI_READ  = 2'b10;
  localparam logic [1:0] RWI_FETCH = 2'b11;
  localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/t07_bus_timer.sv
// t07_bus_timer: counts unacknowledged bus cycles and flags the last permitted one.
module t07_bus_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] count;
  // expired marks the LIMIT-th strobe cycle, so an ack in that same cycle still counts
  assign expired = count == W'(LIMIT - 1);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
endmodule

// File: rtl/t07_mem_arbiter.sv
// t07_mem_arbiter: two-master (CPU / peripheral) arbiter onto a single memory bus with starvation guard and timeout.
module t07_mem_arbiter
  import t07_mem_pkg::*;
#(
  parameter int MAX_CPU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  cpu_rwi,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  input  logic        per_req,
  input  logic        per_we,
  input  logic [31:0] per_addr,
  input  logic [31:0] per_wdata,
  input  logic [3:0]  per_sel,
  output logic [31:0] per_rdata,
  output logic        per_ack,
  output logic        mem_cyc,
  output logic        mem_stb,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);
  localparam int SW = $clog2(MAX_CPU_STREAK + 2);
  arb_state_t state, next;
  logic [SW-1:0] streak;
  logic grant_cpu, grant_per, in_acc, done, expired;
  logic [31:0] fill;
  assign in_acc    = state == CPU_ACC || state == PER_ACC;
  assign done      = in_acc && (mem_ack || expired);
  assign fill      = mem_ack ? mem_rdata : BAD_DATA;
  assign grant_cpu = state == IDLE && cpu_rwi != RWI_IDLE && !(per_req && streak >= SW'(MAX_CPU_STREAK));
  assign grant_per = state == IDLE && per_req && !grant_cpu;
  t07_bus_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (grant_cpu || grant_per),
    .enable (in_acc && !mem_ack),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= next;
  // CPU_DONE is a mandatory gap so the still-asserted cpu_rwi of a finished access is not re-granted
  always_comb begin
    next = state == IDLE     ? (grant_cpu ? CPU_ACC : grant_per ? PER_ACC : IDLE) :
           state == CPU_DONE ? IDLE :
           done              ? (state == CPU_ACC ? CPU_DONE : IDLE) : state;
  end
  always_comb begin
    mem_cyc  = in_acc;
    mem_stb  = in_acc;
    cpu_busy = state == CPU_ACC;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      mem_we    <= 1'b0;
      mem_sel   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      per_rdata <= '0;
      per_ack   <= 1'b0;
      bus_err   <= 1'b0;
      streak    <= '0;
    end else begin
      per_ack <= done && state == PER_ACC;
      bus_err <= done && !mem_ack;
      if (done && state == CPU_ACC) cpu_rdata <= fill;
      if (done && state == PER_ACC) per_rdata <= fill;
      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_we    <= cpu_rwi == RWI_WRITE;
        mem_sel   <= 4'hF;
        streak    <= (per_req && streak < SW'(MAX_CPU_STREAK)) ? streak + 1'b1 : streak;
      end
      if (grant_per) begin
        mem_addr  <= per_addr;
        mem_wdata <= per_wdata;
        mem_we    <= per_we;
        mem_sel   <= per_sel;
        streak    <= '0;
      end
    end
endmodule
